// File: rtl/load_store_unit_if.sv
// Bundle of MEM-stage request, memory bus and writeback signals for the load/store unit.
interface load_store_unit_if #(
  parameter int unsigned BIT_COUNT = 32
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   is_store;
  logic [BIT_COUNT-1:0]   addr;
  logic [BIT_COUNT-1:0]   store_data;
  logic [2:0]             trunc;
  logic [4:0]             rd_in;
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic                   mem_we;
  logic [BIT_COUNT-1:0]   mem_addr;
  logic [BIT_COUNT-1:0]   mem_wdata;
  logic [BIT_COUNT/8-1:0] mem_wstrb;
  logic                   mem_rsp_valid;
  logic [BIT_COUNT-1:0]   mem_rdata;
  logic                   load_valid;
  logic [BIT_COUNT-1:0]   load_data;
  logic [4:0]             load_rd;
  logic                   misaligned;
  logic                   stall;

  modport slave (
    input  req_valid, is_store, addr, store_data, trunc, rd_in,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output req_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output load_valid, load_data, load_rd, misaligned, stall
  );

  modport master (
    output req_valid, is_store, addr, store_data, trunc, rd_in,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  req_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  load_valid, load_data, load_rd, misaligned, stall
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: aligns stores into byte lanes, extracts and
// sign/zero-extends load results, flags misaligned or reserved-size accesses.
module load_store_unit #(
  parameter int unsigned BIT_COUNT = 32
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);
  localparam int unsigned StrbW   = BIT_COUNT / 8;
  localparam int unsigned OffW    = $clog2(StrbW);
  localparam logic [1:0]  FullLog = (BIT_COUNT == 64) ? 2'd3 : 2'd2;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StReq     = 2'd1;
  localparam logic [1:0] StWaitRsp = 2'd2;

  // Returns {legal, signed, log2(size in bytes)}.
  function automatic logic [3:0] decode(input logic [2:0] code);
    logic [3:0] r;
    r = 4'b0000;
    case (code)
      3'd0: r = 4'b1100;
      3'd1: r = 4'b1101;
      3'd2: r = 4'b1110;
      3'd3: r = 4'b1000;
      3'd4: r = 4'b1001;
      3'd5: r = (BIT_COUNT == 64) ? 4'b1010 : {2'b10, FullLog};
      3'd6: r = (BIT_COUNT == 64) ? {2'b10, FullLog} : 4'b0000;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  logic [1:0]           state_q, state_d;
  logic [BIT_COUNT-1:0] addr_q, addr_d, data_q, data_d;
  logic [2:0]           trunc_q, trunc_d;
  logic                 store_q, store_d;
  logic [4:0]           rd_q, rd_d, load_rd_q, load_rd_d;
  logic                 load_valid_q, load_valid_d, misaligned_q, misaligned_d;
  logic [BIT_COUNT-1:0] load_data_q, load_data_d;

  logic [3:0]           req_dec, op_dec;
  logic [OffW-1:0]      req_off, off_q, align_mask;
  logic                 req_err;
  int unsigned          op_bytes, off_int;
  logic [StrbW-1:0]     strb;
  logic [BIT_COUNT-1:0] shifted, mask, result;
  logic                 sign_bit;

  always_comb begin
    req_dec    = decode(bus.trunc);
    req_off    = bus.addr[OffW-1:0];
    align_mask = OffW'((32'd1 << req_dec[1:0]) - 32'd1);
    req_err    = !req_dec[3] || ((req_off & align_mask) != '0);

    op_dec   = decode(trunc_q);
    off_q    = addr_q[OffW-1:0];
    off_int  = 32'(off_q);
    op_bytes = 32'd1 << op_dec[1:0];
    shifted  = bus.mem_rdata >> {off_q, 3'b000};
    strb     = '0;
    mask     = '0;
    sign_bit = 1'b0;
    for (int unsigned i = 0; i < StrbW; i++) begin
      strb[i]         = (i >= off_int) && (i < off_int + op_bytes);
      mask[8*i +: 8]  = (i < op_bytes) ? 8'hFF : 8'h00;
      if (i == op_bytes - 1) sign_bit = shifted[8*i+7];
    end
    result = (shifted & mask) | ((op_dec[2] && sign_bit) ? ~mask : '0);
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    trunc_d      = trunc_q;
    store_d      = store_q;
    rd_d         = rd_q;
    load_valid_d = 1'b0;
    load_data_d  = load_data_q;
    load_rd_d    = load_rd_q;
    misaligned_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (req_err) begin
            misaligned_d = 1'b1;
          end else begin
            addr_d  = bus.addr;
            data_d  = bus.store_data;
            trunc_d = bus.trunc;
            store_d = bus.is_store;
            rd_d    = bus.rd_in;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (bus.mem_req_ready) state_d = store_q ? StIdle : StWaitRsp;
      end
      StWaitRsp: begin
        if (bus.mem_rsp_valid) begin
          load_valid_d = 1'b1;
          load_data_d  = result;
          load_rd_d    = rd_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Clearing the captured operation on reset also zeroes the bus outputs derived from it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      data_q       <= '0;
      trunc_q      <= '0;
      store_q      <= 1'b0;
      rd_q         <= '0;
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
      load_rd_q    <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      trunc_q      <= trunc_d;
      store_q      <= store_d;
      rd_q         <= rd_d;
      load_valid_q <= load_valid_d;
      load_data_q  <= load_data_d;
      load_rd_q    <= load_rd_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign bus.req_ready     = (state_q == StIdle);
  assign bus.stall         = (state_q != StIdle);
  assign bus.mem_req_valid = (state_q == StReq);
  assign bus.mem_we        = (state_q == StReq) && store_q;
  assign bus.mem_addr      = {addr_q[BIT_COUNT-1:OffW], {OffW{1'b0}}};
  assign bus.mem_wdata     = data_q << {off_q, 3'b000};
  assign bus.mem_wstrb     = ((state_q == StReq) && store_q) ? strb : '0;
  assign bus.load_valid    = load_valid_q;
  assign bus.load_data     = load_data_q;
  assign bus.load_rd       = load_rd_q;
  assign bus.misaligned    = misaligned_q;
endmodule
